// File: rtl/conv_controller_if.sv
// Handshake and datapath-control bundle between conv_controller and the 4x4 correlation datapath.
// master = controller side, slave = datapath side.
interface conv_controller_if;
  logic       start;
  logic       done;
  logic       filt_cout;
  logic       input_j_cout;
  logic       calc_done;
  logic       write_mem_cout;
  logic       table_cout;
  logic       it_ends;
  logic       mem_read;
  logic       mem_write;
  logic       x_sel;
  logic       y_sel;
  logic       z_sel;
  logic       x_en;
  logic       y_en;
  logic       z_en;
  logic [1:0] mem_in_sel;
  logic [1:0] input_i_sel;
  logic       filt_ld;
  logic       filt_count_en;
  logic       filt_row_sel;
  logic       input_en;
  logic       input_count_en;
  logic       shift_en;
  logic       in_count_en;
  logic       in_count_ld;
  logic       tab_count_ld;
  logic       count_13_en;
  logic       table_ld;
  logic       mac_ld;
  logic       mac_rst;
  logic       calc_count_en;
  logic       write_buf_ld;
  logic       wr_count_en;
  logic       wr_data_sel;

  modport master (
    input  start, filt_cout, input_j_cout, calc_done, write_mem_cout, table_cout, it_ends,
    output done, mem_read, mem_write, x_sel, y_sel, z_sel, x_en, y_en, z_en, mem_in_sel,
           input_i_sel, filt_ld, filt_count_en, filt_row_sel, input_en, input_count_en,
           shift_en, in_count_en, in_count_ld, tab_count_ld, count_13_en, table_ld, mac_ld,
           mac_rst, calc_count_en, write_buf_ld, wr_count_en, wr_data_sel
  );

  modport slave (
    output start, filt_cout, input_j_cout, calc_done, write_mem_cout, table_cout, it_ends,
    input  done, mem_read, mem_write, x_sel, y_sel, z_sel, x_en, y_en, z_en, mem_in_sel,
           input_i_sel, filt_ld, filt_count_en, filt_row_sel, input_en, input_count_en,
           shift_en, in_count_en, in_count_ld, tab_count_ld, count_13_en, table_ld, mac_ld,
           mac_rst, calc_count_en, write_buf_ld, wr_count_en, wr_data_sel
  );
endinterface

// File: rtl/conv_controller.sv
// Moore sequencer for the 4x4 correlation datapath: loads filter and input rows, steps the
// window across 13 positions per row, writes results back and pulses done after 13 rows.
module conv_controller (
  input logic               clk,
  input logic               rst,
  conv_controller_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StInit, StLdFilt, StLdIn, StTabLd, StCalc, StWrBuf,
    StWrMem, StNextWin, StPart, StPad, StShift, StLdRow, StDone
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] r_q, r_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      r_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    unique case (state_q)
      StIdle:    if (bus.start) state_d = StInit;
      StInit: begin
        r_d     = 2'd0;
        state_d = StLdFilt;
      end
      StLdFilt:  if (bus.filt_cout) state_d = StLdIn;
      StLdIn: begin
        // r tracks the buffer row; the 4th row's last word ends the initial load
        if (bus.input_j_cout) begin
          r_d = r_q + 2'd1;
          if (r_q == 2'd3) state_d = StTabLd;
        end
      end
      StTabLd:   state_d = StCalc;
      StCalc:    if (bus.calc_done) state_d = StWrBuf;
      StWrBuf: begin
        if (bus.table_cout)          state_d = StPart;
        else if (bus.write_mem_cout) state_d = StWrMem;
        else                         state_d = StNextWin;
      end
      StWrMem:   state_d = StNextWin;
      StNextWin: state_d = StTabLd;
      StPart:    state_d = StPad;
      StPad:     if (bus.write_mem_cout) state_d = bus.it_ends ? StDone : StShift;
      StShift:   state_d = StLdRow;
      StLdRow:   if (bus.input_j_cout) state_d = StTabLd;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.done           = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.x_sel          = 1'b0;
    bus.y_sel          = 1'b0;
    bus.z_sel          = 1'b0;
    bus.x_en           = 1'b0;
    bus.y_en           = 1'b0;
    bus.z_en           = 1'b0;
    bus.mem_in_sel     = 2'd0;
    bus.input_i_sel    = 2'd0;
    bus.filt_ld        = 1'b0;
    bus.filt_count_en  = 1'b0;
    bus.filt_row_sel   = 1'b0;
    bus.input_en       = 1'b0;
    bus.input_count_en = 1'b0;
    bus.shift_en       = 1'b0;
    bus.in_count_en    = 1'b0;
    bus.in_count_ld    = 1'b0;
    bus.tab_count_ld   = 1'b0;
    bus.count_13_en    = 1'b0;
    bus.table_ld       = 1'b0;
    bus.mac_ld         = 1'b0;
    bus.mac_rst        = 1'b0;
    bus.calc_count_en  = 1'b0;
    bus.write_buf_ld   = 1'b0;
    bus.wr_count_en    = 1'b0;
    bus.wr_data_sel    = 1'b0;
    unique case (state_q)
      StInit: begin
        bus.x_sel        = 1'b1;
        bus.y_sel        = 1'b1;
        bus.z_sel        = 1'b1;
        bus.x_en         = 1'b1;
        bus.y_en         = 1'b1;
        bus.z_en         = 1'b1;
        bus.tab_count_ld = 1'b1;
        bus.in_count_ld  = 1'b1;
        bus.mac_rst      = 1'b1;
      end
      StLdFilt: begin
        bus.mem_read      = 1'b1;
        bus.mem_in_sel    = 2'd0;
        bus.filt_ld       = 1'b1;
        bus.filt_count_en = 1'b1;
        bus.x_en          = 1'b1;
      end
      StLdIn, StLdRow: begin
        bus.mem_read       = 1'b1;
        bus.mem_in_sel     = 2'd1;
        bus.input_en       = 1'b1;
        bus.input_count_en = 1'b1;
        bus.y_en           = 1'b1;
        bus.input_i_sel    = (state_q == StLdRow) ? 2'd3 : r_q;
      end
      StTabLd: begin
        bus.table_ld = 1'b1;
        bus.mac_rst  = 1'b1;
      end
      StCalc: begin
        bus.mac_ld        = 1'b1;
        bus.calc_count_en = 1'b1;
        bus.filt_row_sel  = 1'b1;
      end
      StWrBuf: begin
        bus.write_buf_ld = 1'b1;
        bus.wr_count_en  = 1'b1;
      end
      StWrMem, StPart: begin
        bus.mem_write   = 1'b1;
        bus.mem_in_sel  = 2'd2;
        bus.wr_data_sel = (state_q == StPart);
        bus.z_en        = 1'b1;
      end
      StNextWin: bus.count_13_en = 1'b1;
      // Pad only advances the write column so the next row starts at column 0
      StPad:     bus.wr_count_en = 1'b1;
      StShift: begin
        bus.shift_en     = 1'b1;
        bus.in_count_en  = 1'b1;
        bus.count_13_en  = 1'b1;
        bus.tab_count_ld = 1'b1;
      end
      StDone:    bus.done = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: doc/conv_controller.md
# conv_controller

Sequencing FSM for the 4×4 correlation datapath. It loads the filter and the input rows from memory and steps the 4×4 window across each row. It drives the MAC and write buffer and writes results back through the x/y/z address counters. It sits beside the datapath at top level, consumes its counter carry-outs and pulses `done` when all 13 output rows are written.

## Interface
- Parameters: none; sizes are fixed by the datapath (4×4 filter, 4×16 input window, 13 windows per row, 13 rows).
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin a job; sampled in IDLE only
- filt_cout, input_j_cout, calc_done, write_mem_cout, table_cout, it_ends  input  1 each  datapath status, combinational, high while the counter sits at its max value
- done  output  1  one-cycle completion pulse
- mem_read, mem_write  output  1 each  memory strobes
- x_sel, y_sel, z_sel  output  1 each  1 = load base address, 0 = increment
- x_en, y_en, z_en  output  1 each  address counter enables
- mem_in_sel  output  2  0 = x (filter), 1 = y (input), 2 = z (output)
- input_i_sel  output  2  input-buffer row being written
- filt_ld, filt_count_en, filt_row_sel, input_en, input_count_en, shift_en, in_count_en, in_count_ld, tab_count_ld, count_13_en, table_ld, mac_ld, mac_rst, calc_count_en, write_buf_ld, wr_count_en, wr_data_sel  output  1 each  datapath controls, same names as datapath inputs

## Operation
- The FSM is Moore: every output is decoded from the state plus an internal 2-bit row counter `r`. Outputs not listed for a state are 0.
- **IDLE**: wait; `start` → INIT.
- **INIT** (1 cycle):
  - Drive `x_sel=y_sel=z_sel=1` and `x_en=y_en=z_en=1`.
  - Drive `tab_count_ld`, `in_count_ld` and `mac_rst`.
  - Clear `r`; → LD_FILT.
- **LD_FILT**:
  - Drive `mem_read`, `mem_in_sel=0`, `filt_ld`, `filt_count_en` and `x_en`.
  - When `filt_cout`=1 → LD_IN. That is 4 cycles.
- **LD_IN**:
  - Drive `mem_read`, `mem_in_sel=1`, `input_en`, `input_count_en`, `y_en`, `input_i_sel=r`.
  - When `input_j_cout`=1, increment `r`. When `r`=3 as well → TAB_LD. That is 16 cycles.
- **TAB_LD** (1 cycle): drive `table_ld` and `mac_rst`; → CALC.
- **CALC**:
  - Drive `mac_ld`, `calc_count_en` and `filt_row_sel=1`.
  - When `calc_done` → WR_BUF. That is 16 cycles.
- **WR_BUF** (1 cycle): drive `write_buf_ld` and `wr_count_en`. Next state, by priority:
  1. `table_cout` → PART.
  2. `write_mem_cout` → WR_MEM.
  3. Otherwise → NEXT_WIN.
- **WR_MEM** (1 cycle):
  - Drive `mem_write`, `mem_in_sel=2`, `wr_data_sel=0` and `z_en`.
  - → NEXT_WIN.
- **NEXT_WIN** (1 cycle): drive `count_13_en`; → TAB_LD.
- **PART** (1 cycle):
  - The 13th window leaves one byte in column 0 of the write buffer.
  - Drive `mem_write`, `mem_in_sel=2`, `wr_data_sel=1` and `z_en`.
  - → PAD.
- **PAD**:
  - Drive `wr_count_en` only, with no buffer load, until `write_mem_cout`. That is 3 cycles, wrapping the write column to 0.
  - Then → DONE if `it_ends`, else → SHIFT.
- **SHIFT** (1 cycle):
  - Drive `shift_en`, `in_count_en` and `count_13_en`. `count_13_en` wraps the table counter from 15 to 0.
  - Drive `tab_count_ld`, which has priority and loads 3.
  - → LD_ROW.
- **LD_ROW**:
  - Same as LD_IN, but with `input_i_sel=3` fixed.
  - When `input_j_cout` → TAB_LD. That is 4 cycles.
- **DONE** (1 cycle): `done=1`; → IDLE.

## Timing
- Reset:
  - Async assert drives the state to IDLE, clears `r` and forces all outputs to 0, including `done`.
  - Release takes effect at the first following clock edge.
  - Reset mid-job abandons the job with no further memory writes.
- `start` outside IDLE is ignored. `start` held high across DONE starts a new job on the IDLE cycle after DONE.
- Status inputs are sampled on the same edge that applies the counting enable. A transition happens on the edge where the counter leaves its max value.
- Per window: TAB_LD 1 + CALC 16 + WR_BUF 1 + NEXT_WIN 1 cycles, plus 1 extra on every 4th window (WR_MEM).
- Per row: 4 full-word writes? No. Each row makes 3 full-word writes (columns 3, 7, 11) and 1 partial write (`wr_data_sel=1`).
- Job total: 13 rows × 13 windows = 169 CALC phases, 39 full writes and 13 partial writes.
- `mem_read` and `mem_write` are never high in the same cycle. `mem_in_sel` is valid whenever either strobe is high.

## Test plan
- **Reset**: `rst`=0 mid-CALC → all outputs 0 the same cycle. After release, `start` → INIT in 1 cycle and `x_sel=x_en=1`.
- **Load phase**: with a datapath model, `start` → exactly 4 `filt_ld` cycles, then 16 `input_en` cycles. `input_i_sel` steps 0,1,2,3, each held 4 cycles.
- **Window loop**: first row → 13 `table_ld` pulses and 208 `mac_ld` cycles.
  - `mem_write` with `wr_data_sel=0` appears after windows 4, 8 and 12.
  - `wr_data_sel=1` appears once after window 13, followed by 3 PAD cycles.
- **Row advance**: after row 1 → 1 `shift_en` cycle with `tab_count_ld`, then 4 reads with `input_i_sel=3`. The table counter restarts at 3.
- **Completion**: full job → 13 `shift_en`-free end at `it_ends`, 52 `mem_write` pulses total and a `done` pulse of exactly 1 cycle. The FSM then returns to IDLE.
- **Start robustness**: `start` pulsed during LD_IN and CALC → no state change. `start` held high → back-to-back jobs separated by a single IDLE cycle.
